// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame geometry and
// frame-length constants. Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int BAUD_DIV_DEF   = 5208;  // 50 MHz / 9600 baud

  // Frame length in bit times: start + data + stop, optionally + parity
  localparam int FRAME_BITS     = DATA_W_DEF + 2;
  localparam int FRAME_BITS_PAR = DATA_W_DEF + 3;

  // FSM state encoding kept as plain constants for legacy tool flows
  typedef logic [2:0] tx_state_t;
  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_START  = 3'd1;
  localparam tx_state_t ST_DATA   = 3'd2;
  localparam tx_state_t ST_PARITY = 3'd3;
  localparam tx_state_t ST_STOP   = 3'd4;

  // Clocks from frame start to completion for a given geometry
  function automatic int frame_clocks(int data_w, int baud_div, bit parity);
    return (data_w + (parity ? 3 : 2)) * baud_div;
  endfunction

endpackage

// File: rtl/tx_engine_if.sv
// Transmit request / serial line bundle between the upstream logic (master)
// and the tx_engine (slave).
interface tx_engine_if
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              load;
  logic [DATA_W-1:0] data_in;
  logic              tx;
  logic              tx_busy;
  logic              tx_done;

  modport master (output load, output data_in, input tx, input tx_busy, input tx_done);
  modport slave  (input load, input data_in, output tx, output tx_busy, output tx_done);
endinterface

// File: rtl/baud_gen.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the terminal count.
// clr holds the counter at zero so a new frame always starts on a full bit.
module baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);
  localparam int            CW   = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] TERM = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = (cnt_q == TERM);

  // Next count: hold at zero while cleared, wrap on terminal count
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || bit_tick) cnt_d = '0;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/tx_engine.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional even
// parity bit, one stop bit. Define TX_PARITY_EN to build in the parity bit.
module tx_engine
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  tx_engine_if.slave bus
);
  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] shreg_shifted;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_tick;
  logic              baud_clr;
`ifdef TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  // Baud timer idles cleared so the accepting edge starts a full start bit
  assign baud_clr      = (state_q == ST_IDLE);
  assign shreg_shifted = shreg_q >> 1;

  baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .clr      (baud_clr),
    .bit_tick (bit_tick)
  );

  // Frame sequencing; tx is computed one edge ahead so the line is registered
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.load) begin
          shreg_d  = bus.data_in;
          bitcnt_d = '0;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_START;
`ifdef TX_PARITY_EN
          parity_d = ^bus.data_in;
`endif
        end
      end
      ST_START: begin
        if (bit_tick) begin
          tx_d    = shreg_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bitcnt_q == LAST_BIT) begin
`ifdef TX_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            shreg_d  = shreg_shifted;
            tx_d     = shreg_shifted[0];
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_tick) begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any frame and wins over a same-edge load
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;
endmodule

// File: doc/tx_engine.md
TX_ENGINE -- requirements
Module: tx_engine

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 5208, clocks per serial bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have parameter DATA_W, default 8, number of data bits per frame.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset.
REQ-005 SHALL make reset synchronous and active-high: it is sampled on the rising edge of clk only.
REQ-006 SHALL have port load  input  1  single-cycle transmit request pulse from the upstream edge detector.
REQ-007 SHALL have port data_in  input  DATA_W  byte to transmit; sampled only on an accepted load.
REQ-008 SHALL have port tx  output  1  serial line; idle high.
REQ-009 SHALL have port tx_busy  output  1  high while a frame is in progress.
REQ-010 SHALL have port tx_done  output  1  single-cycle pulse marking frame completion.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL accept load only in IDLE; on the accepting edge it latches data_in into a shift register, clears the baud and bit counters, and enters START.
REQ-013 SHALL ignore load in any non-IDLE state; data_in changes mid-frame have no effect.
REQ-014 SHALL make tx and tx_busy registered outputs: on the edge that accepts load, tx goes 0 and tx_busy goes 1, so both change one cycle after load is sampled.
REQ-015 SHALL hold each bit for exactly BAUD_DIV clocks, timed by a baud counter that counts 0..BAUD_DIV-1 and wraps, and emits bit_tick on its terminal count.
REQ-016 SHALL drive the frame in this order:
  - start bit 0
  - DATA_W data bits, LSB first
  - optional parity bit (see REQ-024)
  - one stop bit 1
REQ-017 SHALL use a bit counter in DATA that runs 0..DATA_W-1 and leaves DATA on bit_tick when the count equals DATA_W-1.
REQ-018 SHALL, on bit_tick in STOP:
  - return to IDLE
  - clear tx_busy
  - assert tx_done for exactly one cycle on that same edge
  - keep tx at 1
REQ-019 SHALL accept a load arriving in the first IDLE cycle after tx_done (back-to-back frames) with no idle bit inserted.
REQ-020 SHALL make total frame time, from the accepting edge to tx_done, exactly (DATA_W+2)*BAUD_DIV clocks, or (DATA_W+3)*BAUD_DIV clocks with parity.

Reset
REQ-021 SHALL, on rst high, set the following on the next clock edge regardless of state:
  - tx = 1
  - tx_busy = 0
  - tx_done = 0
  - FSM = IDLE
  - baud counter, bit counter and shift register = 0
REQ-022 SHALL abort a frame when reset occurs mid-frame, with no stop bit or tx_done emitted.
REQ-023 SHALL give rst priority over a simultaneous load; the load is lost.

Configuration
REQ-024 SHALL insert the PARITY state when macro TX_PARITY_EN is defined: one bit time of even parity (XOR of the latched data bits), placed after the last data bit and before STOP.
REQ-025 SHALL go from DATA directly to STOP when TX_PARITY_EN is undefined; the PARITY state and the parity logic are not synthesised.

Structure
REQ-026 SHALL put the following in shared package uart_pkg, reused by the receiver:
  - FSM state typedef (IDLE, START, DATA, PARITY, STOP)
  - DATA_W default
  - default BAUD_DIV
  - frame-length constants
REQ-027 SHALL place the baud counter in sub-module baud_gen (ports clk, rst, clr, bit_tick), instantiated once.

Verification (bench BAUD_DIV=4, DATA_W=8)
REQ-028 SHALL check: load pulse with data_in=0x55, parity off -> tx sequence 0,1,0,1,0,1,0,1,0,1, each held 4 clocks; tx_done exactly 40 clocks after the accepting edge.
REQ-029 SHALL check: TX_PARITY_EN defined, data_in=0x07 -> parity bit 1 after the data bits; tx_done at 44 clocks.
REQ-030 SHALL check: second load with data_in=0xFF asserted 12 clocks into a 0xA3 frame -> ignored; line carries only 0xA3; a single tx_done.
REQ-031 SHALL check: rst asserted 17 clocks into a frame -> next edge tx=1, tx_busy=0; no tx_done; a following load with 0x3C transmits correctly.
REQ-032 SHALL check: load asserted on the cycle immediately after tx_done -> the new start bit begins with no idle gap; both frames decode correctly.
REQ-033 SHALL check: rst and load high on the same edge -> tx stays 1 and tx_busy 0 for 50 clocks.
